ls_queue_unit: RTL and testbench
================================

Name: ls_queue_unit

Overview:
- Parametrised load/store execution unit with an in-order request queue of DEPTH entries.
- Accepts operand-ready memory ops from issue and presents one request at a time to the cache over a valid/ready handshake.
- Sign/zero-extends load results and writes them back to the register file.
- Supports flush, with safe discard of an in-flight load response.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries (power of two, >=2)
RA_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low freezes all state
flush  in  1  discard queued ops and any in-flight load
in_valid  in  1  op offered
in_ready  out  1  queue can accept
in_op  in  4  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW
in_base  in  XLEN  base register value
in_imm  in  XLEN  sign-extended offset
in_src  in  XLEN  store data
in_rd  in  RA_W  load destination
mem_req_valid  out  1  request valid
mem_req_ready  in  1  cache accepts request
mem_req_we  out  1  1 store, 0 load
mem_req_addr  out  XLEN  in_base+in_imm
mem_req_size  out  3  bytes: 1, 2 or 4
mem_req_wdata  out  XLEN  store data, low bytes used
mem_resp_valid  in  1  load data returned (one-cycle pulse)
mem_resp_data  in  XLEN  little-endian; byte at addr in [7:0]
wb_valid  out  1  register write, one-cycle pulse
wb_rd  out  RA_W  destination
wb_data  out  XLEN  extended load result
count  out  clog2(DEPTH)+1  occupancy
busy  out  1  count!=0 or state!=ISSUE or drop_pending

Behaviour:
- Reset: queue empty, count=0, state=ISSUE, drop_pending=0, wb_valid=0, wb_rd=0, wb_data=0. Combinational outputs follow from this state.
- rdy=0: no state change. in_ready=0, mem_req_valid=0, wb_valid holds. The cache shares rdy and does not respond while it is low.
- Push:
  - in_ready = rdy & !flush & count<DEPTH.
  - Push on in_valid&in_ready.
  - Address is computed at push, modulo 2^XLEN.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Illegal in_op: accepted, then popped from head with no request and no writeback.
- Request outputs: driven combinationally from the head entry.
  - mem_req_valid = rdy & count!=0 & state==ISSUE & !drop_pending & head legal.
  - Payload is stable while valid is high and ready is low.
- FSM ISSUE:
  - Store handshake: pop; stay in ISSUE. Stores produce no writeback.
  - Load handshake: go to WAIT; the head stays in the queue.
- FSM WAIT:
  - On mem_resp_valid: pop and go to ISSUE.
  - Next edge: wb_valid=1, wb_rd=head rd, wb_data=extension of mem_resp_data.
  - If rd==0, wb_valid stays 0.
- Extension rules:
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: [31:0].
- Minimum load latency: push at edge N -> request visible in cycle N+1 -> response earliest in cycle N+2 -> wb_valid in cycle N+3.
- Flush (rdy=1):
  - Queue cleared, count=0, state=ISSUE, wb_valid=0 next cycle.
  - A same-cycle push is ignored. A request handshaking in the same cycle is accepted by the cache but its response is dropped.
  - If state was WAIT, or a load handshake coincides with flush, drop_pending=1. The next mem_resp_valid clears it and is ignored.
  - No request is issued while drop_pending=1.
  - A response arriving in the flush cycle itself satisfies drop_pending (drop_pending stays 0).
- mem_resp_valid in ISSUE with drop_pending=0 is a protocol error and is ignored.
- Stores are not ordered against outside traffic; ordering is strictly queue order.

Test Plan:
- base=0x100, imm=-4, LW, rd=3, resp 0x80000001 -> req addr 0xFC, size 4; wb_valid one cycle after resp, wb_rd=3, wb_data=0x80000001.
- LB/LBU/LH/LHU on resp 0x0000F080 -> wb_data 0xFFFFFF80, 0x00000080, 0xFFFFF080, 0x0000F080.
- Push DEPTH=4 stores with mem_req_ready=0 -> in_ready=0, count=4; release ready -> four requests in push order, one per cycle, no wb_valid.
- Load in WAIT plus flush, then a resp 3 cycles later, then a new LW -> first resp ignored, no wb_valid; new LW issued only after that resp.
- LW with rd=0 -> memory request issued, wb_valid never asserted, count returns to 0.
- rdy=0 for 5 cycles mid-REQ -> mem_req_valid=0; count, state and payload unchanged; resumes identically when rdy=1.

Source files
------------

// File: rtl/ls_queue_unit.sv
// Load/store unit: in-order queue of memory ops feeding a valid/ready cache port,
// with load-result extension, register writeback and flush with response dropping.
module ls_queue_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RA_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [XLEN-1:0]          in_base,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [XLEN-1:0]          in_src,
    input  logic [RA_W-1:0]          in_rd,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [2:0]               mem_req_size,
    output logic [XLEN-1:0]          mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic                     wb_valid,
    output logic [RA_W-1:0]          wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_ISSUE, ST_WAIT} state_t;

    logic [3:0]      entryOp_q   [DEPTH];
    logic [XLEN-1:0] entryAddr_q [DEPTH];
    logic [XLEN-1:0] entryData_q [DEPTH];
    logic [RA_W-1:0] entryRd_q   [DEPTH];

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic            drop_q, drop_d;
    logic            wbValid_q, wbValid_d;
    logic [RA_W-1:0] wbRd_q, wbRd_d;
    logic [XLEN-1:0] wbData_q, wbData_d;

    logic [3:0]      headOp;
    logic            headLegal, headStore, issueSlot, reqHs, push, pop, respPop, illegalPop;

    function automatic logic opLegal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: opLegal = 1'b1;
            default:                                       opLegal = 1'b0;
        endcase
    endfunction

    // op[1:0] selects width, op[2] selects zero extension for sub-word loads
    function automatic logic [XLEN-1:0] loadExt(input logic [3:0] op, input logic [XLEN-1:0] d);
        case (op[1:0])
            2'd0:    loadExt = op[2] ? XLEN'(d[7:0])  : {{(XLEN-8){d[7]}},   d[7:0]};
            2'd1:    loadExt = op[2] ? XLEN'(d[15:0]) : {{(XLEN-16){d[15]}}, d[15:0]};
            default: loadExt = XLEN'(d[31:0]);
        endcase
    endfunction

    assign headOp     = entryOp_q[head_q];
    assign headLegal  = opLegal(headOp);
    assign headStore  = headOp[3];
    assign issueSlot  = rdy && (count_q != '0) && (state_q == ST_ISSUE) && !drop_q;

    assign mem_req_valid = issueSlot && headLegal;
    assign mem_req_we    = headStore;
    assign mem_req_addr  = entryAddr_q[head_q];
    assign mem_req_wdata = entryData_q[head_q];
    assign mem_req_size  = (headOp[1:0] == 2'd0) ? 3'd1 : (headOp[1:0] == 2'd1) ? 3'd2 : 3'd4;

    assign in_ready   = rdy && !flush && (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign reqHs      = mem_req_valid && mem_req_ready;
    assign illegalPop = issueSlot && !headLegal;
    assign respPop    = rdy && (state_q == ST_WAIT) && mem_resp_valid;
    assign pop        = (reqHs && headStore) || respPop || illegalPop;

    assign wb_valid = wbValid_q;
    assign wb_rd    = wbRd_q;
    assign wb_data  = wbData_q;
    assign count    = count_q;
    assign busy     = (count_q != '0) || (state_q != ST_ISSUE) || drop_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        drop_d    = drop_q;
        wbValid_d = wbValid_q;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        if (rdy) begin
            if (flush) begin
                head_d    = '0;
                tail_d    = '0;
                count_d   = '0;
                state_d   = ST_ISSUE;
                wbValid_d = 1'b0;
                // a response landing in the flush cycle already retires the outstanding load
                drop_d    = (drop_q || (state_q == ST_WAIT) || (reqHs && !headStore)) && !mem_resp_valid;
            end else begin
                wbValid_d = 1'b0;
                if (push) tail_d = tail_q + PW'(1);
                if (pop)  head_d = head_q + PW'(1);
                count_d = count_q + CW'(push) - CW'(pop);
                if (reqHs && !headStore) state_d = ST_WAIT;
                if (respPop) begin
                    state_d = ST_ISSUE;
                    if (entryRd_q[head_q] != '0) begin
                        wbValid_d = 1'b1;
                        wbRd_d    = entryRd_q[head_q];
                        wbData_d  = loadExt(headOp, mem_resp_data);
                    end
                end
                if (drop_q && mem_resp_valid) drop_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= ST_ISSUE;
            drop_q    <= 1'b0;
            wbValid_q <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            drop_q    <= drop_d;
            wbValid_q <= wbValid_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
        end
    end

    // queue storage needs no reset; count/pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            entryOp_q[tail_q]   <= in_op;
            entryAddr_q[tail_q] <= in_base + in_imm;
            entryData_q[tail_q] <= in_src;
            entryRd_q[tail_q]   <= in_rd;
        end
    end
endmodule

// File: tb/tb_ls_queue_unit.sv
// Directed testbench for ls_queue_unit: loads, extension, store backpressure,
// flush with dropped response, rd=0 loads, illegal ops and rdy freeze.
module tb_ls_queue_unit;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_base, in_imm, in_src;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [2:0]  mem_req_size;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  count;
    logic        busy;

    int vectorCount = 0;
    int missCount   = 0;

    ls_queue_unit #(.XLEN(32), .DEPTH(4), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_base(in_base), .in_imm(in_imm), .in_src(in_src), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] base,
                                 input logic [31:0] imm, input logic [31:0] src, input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_base  = base;
        in_imm   = imm;
        in_src   = src;
        in_rd    = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // push one load, handshake immediately, answer one cycle later, check writeback
    task automatic doLoad(input string tag, input logic [3:0] op, input logic [4:0] rd,
                          input logic [31:0] base, input logic [31:0] imm, input logic [31:0] expAddr,
                          input logic [2:0] expSize, input logic [31:0] resp, input logic [31:0] expData);
        mem_req_ready = 1'b1;
        applyStimulus(1'b1, op, base, imm, 32'h0, rd);
        #1 checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
        checkOutput({tag, " req_addr"}, mem_req_addr, expAddr);
        checkOutput({tag, " req_size"}, 32'(mem_req_size), 32'(expSize));
        checkOutput({tag, " req_we"}, 32'(mem_req_we), 32'd0);
        tick();
        checkOutput({tag, " wait_req_valid"}, 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp;
        #1 checkOutput({tag, " early_wb"}, 32'(wb_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput({tag, " wb_valid"}, 32'(wb_valid), (rd != 5'd0) ? 32'd1 : 32'd0);
        if (rd != 5'd0) begin
            checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
            checkOutput({tag, " wb_data"}, wb_data, expData);
        end
        checkOutput({tag, " count"}, 32'(count), 32'd0);
        tick();
        checkOutput({tag, " wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  stOp   [4];
        logic [31:0] stBase [4];
        logic [31:0] stImm  [4];
        logic [31:0] stData [4];
        logic [31:0] stAddr [4];
        logic [2:0]  stSize [4];
        stOp = '{4'd10, 4'd8, 4'd9, 4'd10};
        stBase = '{32'h1000, 32'h1000, 32'h2000, 32'hFFFFFFFC};
        stImm  = '{32'h0, 32'h5, 32'hFFFFFFFE, 32'h8};
        stData = '{32'h11111111, 32'h000000AB, 32'h0000BEEF, 32'hCAFEF00D};
        stAddr = '{32'h1000, 32'h1005, 32'h1FFE, 32'h4};
        stSize = '{3'd4, 3'd1, 3'd2, 3'd4};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("reset wb_data", wb_data, 32'd0);
        checkOutput("reset req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);

        doLoad("lw",  4'd2, 5'd3, 32'h100, 32'hFFFFFFFC, 32'hFC,  3'd4, 32'h80000001, 32'h80000001);
        doLoad("lb",  4'd0, 5'd4, 32'h200, 32'h1,        32'h201, 3'd1, 32'h0000F080, 32'hFFFFFF80);
        doLoad("lbu", 4'd4, 5'd5, 32'h200, 32'h2,        32'h202, 3'd1, 32'h0000F080, 32'h00000080);
        doLoad("lh",  4'd1, 5'd6, 32'h200, 32'h4,        32'h204, 3'd2, 32'h0000F080, 32'hFFFFF080);
        doLoad("lhu", 4'd5, 5'd7, 32'h200, 32'h6,        32'h206, 3'd2, 32'h0000F080, 32'h0000F080);
        doLoad("rd0", 4'd2, 5'd0, 32'h300, 32'h0,        32'h300, 3'd4, 32'h55555555, 32'h0);

        // four stores against a stalled cache, then drain in push order
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, stOp[i], stBase[i], stImm[i], stData[i], 5'd0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checkOutput("st full count", 32'(count), 32'd4);
        checkOutput("st full in_ready", 32'(in_ready), 32'd0);
        checkOutput("st stall addr", mem_req_addr, stAddr[0]);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("st%0d valid", i), 32'(mem_req_valid), 32'd1);
            checkOutput($sformatf("st%0d we", i), 32'(mem_req_we), 32'd1);
            checkOutput($sformatf("st%0d addr", i), mem_req_addr, stAddr[i]);
            checkOutput($sformatf("st%0d wdata", i), mem_req_wdata, stData[i]);
            checkOutput($sformatf("st%0d size", i), 32'(mem_req_size), 32'(stSize[i]));
            checkOutput($sformatf("st%0d wb", i), 32'(wb_valid), 32'd0);
            tick();
        end
        #1;
        checkOutput("st drained valid", 32'(mem_req_valid), 32'd0);
        checkOutput("st drained count", 32'(count), 32'd0);
        checkOutput("st drained wb", 32'(wb_valid), 32'd0);

        // illegal op is swallowed without a request or writeback
        applyStimulus(1'b1, 4'd3, 32'h700, 32'h0, 32'h0, 5'd9);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("ill count", 32'(count), 32'd1);
        checkOutput("ill req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        checkOutput("ill popped", 32'(count), 32'd0);
        checkOutput("ill wb", 32'(wb_valid), 32'd0);

        // rdy freeze while a load request is pending
        mem_req_ready = 1'b0;
        applyStimulus(1'b1, 4'd2, 32'h300, 32'h10, 32'h0, 5'd7);
        tick();
        in_valid = 1'b0;
        #1 checkOutput("frz pre valid", 32'(mem_req_valid), 32'd1);
        rdy = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("frz%0d valid", i), 32'(mem_req_valid), 32'd0);
            checkOutput($sformatf("frz%0d in_ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("frz%0d count", i), 32'(count), 32'd1);
            checkOutput($sformatf("frz%0d addr", i), mem_req_addr, 32'h310);
            checkOutput($sformatf("frz%0d busy", i), 32'(busy), 32'd1);
            tick();
        end
        rdy = 1'b1;
        #1;
        checkOutput("frz resume valid", 32'(mem_req_valid), 32'd1);
        checkOutput("frz resume addr", mem_req_addr, 32'h310);
        tick();
        checkOutput("frz wait valid", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h00000042;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("frz wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("frz wb_rd", 32'(wb_rd), 32'd7);
        checkOutput("frz wb_data", wb_data, 32'h00000042);
        tick();

        // flush while a load is outstanding; its late response must be dropped
        mem_req_ready = 1'b1;
        applyStimulus(1'b1, 4'd2, 32'h400, 32'h0, 32'h0, 5'd5);
        tick();
        in_valid = 1'b0;
        #1 checkOutput("fl req_valid", 32'(mem_req_valid), 32'd1);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 4'd10, 32'h900, 32'h0, 32'h0, 5'd0);
        #1 checkOutput("fl in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, 4'd2, 32'h500, 32'h4, 32'h0, 5'd6);
        #1;
        checkOutput("fl count", 32'(count), 32'd0);
        checkOutput("fl busy", 32'(busy), 32'd1);
        checkOutput("fl wb", 32'(wb_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        checkOutput("fl new count", 32'(count), 32'd1);
        checkOutput("fl blocked1", 32'(mem_req_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        #1 checkOutput("fl blocked2", 32'(mem_req_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("fl dropped wb", 32'(wb_valid), 32'd0);
        checkOutput("fl new valid", 32'(mem_req_valid), 32'd1);
        checkOutput("fl new addr", mem_req_addr, 32'h504);
        tick();
        checkOutput("fl new wait", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h12345678;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("fl new wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("fl new wb_rd", 32'(wb_rd), 32'd6);
        checkOutput("fl new wb_data", wb_data, 32'h12345678);
        checkOutput("fl new count0", 32'(count), 32'd0);
        tick();
        checkOutput("fl idle busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
